mem_arbiter: RTL

Multi-cycle arbiter that shares the single-port unified memory between the instruction-fetch port and the data port of the WISC-S15 core. The data port serves LW/SW/CALL/RET, i.e. the MemRead/MemWrite requests from the control logic. It issues one access at a time to a fixed-latency memory and returns read data with a one-cycle acknowledge. It drives per-port stall signals so the pipeline freezes while its access is pending.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals shared by mem_arbiter.
// The arbiter connects as slave; the core/memory side (or a bench) drives the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and the data port,
// one access at a time, with round-robin tie-breaking and per-port stall outputs.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  state_e            state_q;
  grant_e            grant_q;
  grant_e            last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ack_q;
  logic              d_ack_q;
  grant_e            winner_s;

  // Winner selection: a tie goes to whichever port did not win last time.
  always_comb begin
    winner_s = GNT_FETCH;
    if (bus.d_req && bus.if_req) begin
      winner_s = (last_grant_q == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (bus.d_req) begin
      winner_s = GNT_DATA;
    end else begin
      winner_s = GNT_FETCH;
    end
  end

  // Access sequencer: the memory-side registers double as the latched request for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_FETCH;
      last_grant_q <= GNT_FETCH;
      cnt_q        <= {CNT_W{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      if_rdata_q   <= {DATA_W{1'b0}};
      d_rdata_q    <= {DATA_W{1'b0}};
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            grant_q      <= winner_s;
            last_grant_q <= winner_s;
            mem_en_q     <= 1'b1;
            if (winner_s == GNT_DATA) begin
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_wdata_q <= {DATA_W{1'b0}};
            end
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          cnt_q    <= CNT_W'(MEM_LAT);
          state_q  <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          // Count of one marks the cycle in which mem_rdata is valid.
          if (cnt_q == CNT_W'(1)) begin
            if (!mem_we_q) begin
              if (grant_q == GNT_DATA) begin
                d_rdata_q <= bus.mem_rdata;
              end else begin
                if_rdata_q <= bus.mem_rdata;
              end
            end
            if_ack_q <= (grant_q == GNT_FETCH);
            d_ack_q  <= (grant_q == GNT_DATA);
            state_q  <= ACK;
          end else begin
            state_q <= WAIT;
          end
        end
        ACK: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          mem_en_q <= 1'b0;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.d_stall   = bus.d_req & ~d_ack_q;
endmodule
